// File: rtl/nto1_lane_packer_pkg.sv
// Shared types and helpers for the N-to-1 lane packer.
// Holds the buffer state encoding and the lane popcount used to size writes.
package nto1_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  localparam int MAX_LANES = 64;

  function automatic int unsigned lane_popcount(input logic [MAX_LANES-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_LANES; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/nto1_lane_packer_if.sv
// Bundle of the writer-side and downstream-FIFO-side signals of the lane packer.
// The master drives writes and downstream back-pressure; the slave is the packer.
interface nto1_lane_packer_if #(
  parameter int WIDTH     = 8,
  parameter int N_WRITERS = 2,
  parameter int PK_WIDTH  = 64,
  localparam int LANES    = PK_WIDTH / WIDTH
) (
  input logic i_clk
);

  logic [N_WRITERS-1:0]       wr_en;
  logic [N_WRITERS*WIDTH-1:0] wr_data;
  logic                       wr_full;
  logic                       flush;
  logic                       pk_full;
  logic                       pk_valid;
  logic [PK_WIDTH-1:0]        pk_data;
  logic [LANES-1:0]           pk_mask;

  modport master (
    input  i_clk,
    output wr_en, wr_data, flush, pk_full,
    input  wr_full, pk_valid, pk_data, pk_mask
  );

  modport slave (
    input  i_clk,
    input  wr_en, wr_data, flush, pk_full,
    output wr_full, pk_valid, pk_data, pk_mask
  );

endinterface

// File: rtl/nto1_lane_packer.sv
// Packs up to N_WRITERS narrow lanes per cycle into PK_WIDTH-wide words for a downstream FIFO.
// A current word (pk0) plus an overflow word (pk1) let writers keep streaming while a word is emitted.
module nto1_lane_packer
  import nto1_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int N_WRITERS = 2,
  parameter int PK_WIDTH  = 64,
  localparam int LANES    = PK_WIDTH / WIDTH
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [N_WRITERS-1:0]       i_wr_en,
  input  logic [N_WRITERS*WIDTH-1:0] i_wr_data,
  output logic                       o_wr_full,
  input  logic                       i_flush,
  input  logic                       i_pk_full,
  output logic                       o_pk_valid,
  output logic [PK_WIDTH-1:0]        o_pk_data,
  output logic [LANES-1:0]           o_pk_mask
);

  localparam int CW = $clog2(LANES + 1);
  localparam int SW = CW + 1;

  logic [PK_WIDTH-1:0] r_pk0;
  logic [PK_WIDTH-1:0] r_pk1;
  logic [CW-1:0]       r_cnt0;
  logic [CW-1:0]       r_cnt1;
  logic                r_flush_pend;
  state_t              r_state;
  logic                r_pk_valid;
  logic [PK_WIDTH-1:0] r_pk_data;
  logic [LANES-1:0]    r_pk_mask;

  logic [SW-1:0]         w_free;
  logic                  w_wr_full;
  logic [N_WRITERS-1:0]  w_accept;
  logic                  w_emit;
  logic [SW-1:0]         w_base;
  logic [SW-1:0]         w_total;
  int                    w_idx;
  logic [2*PK_WIDTH-1:0] w_comb;
  logic [PK_WIDTH-1:0]   w_pk0_n;
  logic [PK_WIDTH-1:0]   w_pk1_n;
  logic [CW-1:0]         w_cnt0_n;
  logic [CW-1:0]         w_cnt1_n;
  logic                  w_flush_n;
  state_t                w_state_n;
  logic [LANES-1:0]      w_lane_mask;
  logic [PK_WIDTH-1:0]   w_emit_data;

  // Refuse a whole cycle of writes unless every writer could be placed.
  assign w_free    = SW'(LANES) - SW'(r_cnt0) + SW'(LANES) - SW'(r_cnt1);
  assign w_wr_full = (w_free < SW'(N_WRITERS));
  assign w_accept  = i_wr_en & {N_WRITERS{~w_wr_full}};
  assign w_emit    = (r_state == ST_READY) && !i_pk_full;

  // While pk0 leaves this cycle, new lanes land after pk1's contents so they survive the shift.
  always_comb begin
    w_base  = w_emit ? (SW'(LANES) + SW'(r_cnt1)) : (SW'(r_cnt0) + SW'(r_cnt1));
    w_total = w_base + SW'(lane_popcount(MAX_LANES'(w_accept)));
    w_comb  = {r_pk1, r_pk0};
    w_idx   = int'(w_base);
    for (int r = 0; r < N_WRITERS; r++) begin
      if (w_accept[r]) begin
        w_comb[w_idx*WIDTH +: WIDTH] = i_wr_data[r*WIDTH +: WIDTH];
        w_idx = w_idx + 1;
      end
    end
  end

  always_comb begin
    w_pk0_n  = w_comb[PK_WIDTH-1:0];
    w_pk1_n  = w_comb[2*PK_WIDTH-1:PK_WIDTH];
    w_cnt0_n = r_cnt0;
    w_cnt1_n = r_cnt1;
    if (w_emit) begin
      w_pk0_n  = w_comb[2*PK_WIDTH-1:PK_WIDTH];
      w_pk1_n  = '0;
      w_cnt0_n = CW'(w_total - SW'(LANES));
      w_cnt1_n = '0;
    end else if (w_total >= SW'(LANES)) begin
      w_cnt0_n = CW'(LANES);
      w_cnt1_n = CW'(w_total - SW'(LANES));
    end else begin
      w_cnt0_n = CW'(w_total);
      w_cnt1_n = '0;
    end

    // A pending flush drains everything buffered, including lanes that arrive meanwhile.
    w_flush_n = r_flush_pend;
    if (w_emit && (w_cnt0_n == '0)) begin
      w_flush_n = 1'b0;
    end
    if (i_flush && (w_cnt0_n != '0)) begin
      w_flush_n = 1'b1;
    end

    if ((w_cnt0_n == CW'(LANES)) || w_flush_n) begin
      w_state_n = ST_READY;
    end else if (w_cnt0_n == '0) begin
      w_state_n = ST_EMPTY;
    end else begin
      w_state_n = ST_FILL;
    end
  end

  always_comb begin
    w_lane_mask = '0;
    w_emit_data = '0;
    for (int l = 0; l < LANES; l++) begin
      w_lane_mask[l] = (CW'(l) < r_cnt0);
      w_emit_data[l*WIDTH +: WIDTH] = w_lane_mask[l] ? r_pk0[l*WIDTH +: WIDTH] : '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pk0        <= '0;
      r_pk1        <= '0;
      r_cnt0       <= '0;
      r_cnt1       <= '0;
      r_flush_pend <= 1'b0;
      r_state      <= ST_EMPTY;
      r_pk_valid   <= 1'b0;
      r_pk_data    <= '0;
      r_pk_mask    <= '0;
    end else begin
      r_pk0        <= w_pk0_n;
      r_pk1        <= w_pk1_n;
      r_cnt0       <= w_cnt0_n;
      r_cnt1       <= w_cnt1_n;
      r_flush_pend <= w_flush_n;
      r_state      <= w_state_n;
      r_pk_valid   <= w_emit;
      if (w_emit) begin
        r_pk_data <= w_emit_data;
        r_pk_mask <= w_lane_mask;
      end
    end
  end

  assign o_wr_full  = w_wr_full;
  assign o_pk_valid = r_pk_valid;
  assign o_pk_data  = r_pk_data;
  assign o_pk_mask  = r_pk_mask;

endmodule
